// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_HEADER = 3'd0,
    S_WORDS  = 3'd1,
    S_CHECK  = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HEADER_BYTES   = 4;
  localparam int unsigned BYTE_WIDTH     = 8;
  localparam int unsigned WORD_WIDTH     = 32;
  localparam int unsigned ADDR_WIDTH     = 64;

endpackage

// File: rtl/byte_assembler.sv
// Little-endian byte-to-word assembler shared by the header and word phases.
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word_c,
  output logic        word_complete_c
);

  logic [1:0]  idx;
  logic [23:0] shreg;

  // Byte index and shift register; newest byte enters at the top so byte 0 ends at [7:0].
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx   <= '0;
      shreg <= '0;
    end else if (clear) begin
      idx   <= '0;
      shreg <= '0;
    end else if (byte_valid) begin
      idx   <= idx + 2'd1;
      shreg <= {byte_data, shreg[23:8]};
    end
  end

  // The fourth byte completes the word combinationally so the FSM can act on the same edge.
  assign word_c          = {byte_data, shreg};
  assign word_complete_c = byte_valid && (idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Boot loader: header count, little-endian instruction words, XOR checksum, core release.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH  = 256,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  output logic                   imem_we,
  output logic [63:0]            imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   core_reset,
  output logic                   load_done,
  output logic                   load_error,
  output logic [COUNT_WIDTH-1:0] words_loaded
);

  state_t                 state;
  state_t                 state_next;
  logic                   accept_c;
  logic [31:0]            word_c;
  logic                   word_done_c;
  logic                   header_bad_c;
  logic                   last_word_c;
  logic [7:0]             csum;
  logic [COUNT_WIDTH-1:0] word_count;
  logic                   rx_ready_next;
  logic                   core_reset_next;
  logic                   load_done_next;
  logic                   load_error_next;

  // A byte taken in the same cycle as start is dropped.
  assign accept_c     = rx_valid && rx_ready && !start;
  assign header_bad_c = (word_c == 32'd0) || (word_c > 32'(IMEM_DEPTH));
  assign last_word_c  = (words_loaded + COUNT_WIDTH'(1)) == word_count;

  byte_assembler u_asm (
    .clock           (clock),
    .reset           (reset),
    .clear           (start),
    .byte_valid      (accept_c),
    .byte_data       (rx_data),
    .word_c          (word_c),
    .word_complete_c (word_done_c)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_HEADER;
    else       state <= state_next;
  end

  // Next-state logic; start overrides everything.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = S_HEADER;
    end else begin
      case (state)
        S_HEADER: if (word_done_c) state_next = header_bad_c ? S_ERROR : S_WORDS;
        S_WORDS:  if (word_done_c && last_word_c) state_next = S_CHECK;
        S_CHECK:  if (accept_c) state_next = (rx_data == csum) ? S_DONE : S_ERROR;
        default:  state_next = state;
      endcase
    end
  end

  // Status outputs decoded from the upcoming state, then registered.
  always_comb begin
    rx_ready_next   = 1'b0;
    core_reset_next = 1'b1;
    load_done_next  = 1'b0;
    load_error_next = 1'b0;
    case (state_next)
      S_HEADER, S_WORDS, S_CHECK: rx_ready_next = 1'b1;
      S_DONE: begin
        core_reset_next = 1'b0;
        load_done_next  = 1'b1;
      end
      S_ERROR: load_error_next = 1'b1;
      default: rx_ready_next = 1'b0;
    endcase
  end

  // Status output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_ready   <= 1'b1;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      rx_ready   <= rx_ready_next;
      core_reset <= core_reset_next;
      load_done  <= load_done_next;
      load_error <= load_error_next;
    end
  end

  // Datapath: word count capture, checksum, and the one-cycle instruction memory write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      csum         <= '0;
      word_count   <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
    end else begin
      imem_we <= 1'b0;
      if (start) begin
        csum         <= '0;
        word_count   <= '0;
        words_loaded <= '0;
      end else begin
        if (state == S_HEADER && word_done_c) begin
          word_count <= word_c[COUNT_WIDTH-1:0];
        end
        if (state == S_WORDS && accept_c) begin
          csum <= csum ^ rx_data;
        end
        if (state == S_WORDS && word_done_c) begin
          imem_we      <= 1'b1;
          imem_addr    <= 64'(words_loaded) << 2;
          imem_wdata   <= word_c;
          words_loaded <= words_loaded + COUNT_WIDTH'(1);
        end
      end
    end
  end

endmodule
